// File: rtl/stream_demux_1ton_if.sv
// Stream bundle for the 1-to-N demultiplexer: one upstream port and NUM_OUT
// downstream channels that share a single data/last bus.
interface stream_demux_1ton_if #(
    parameter int DATA_W  = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 3
);
    logic               s_valid;
    logic               s_ready;
    logic [DATA_W-1:0]  s_data;
    logic               s_last;
    logic [SEL_W-1:0]   s_sel;
    logic [NUM_OUT-1:0] m_valid;
    logic [NUM_OUT-1:0] m_ready;
    logic [DATA_W-1:0]  m_data;
    logic               m_last;

    // slave: the demux itself; master: the producer/consumer environment
    modport slave (
        input  s_valid, s_data, s_last, s_sel, m_ready,
        output s_ready, m_valid, m_data, m_last
    );
    modport master (
        output s_valid, s_data, s_last, s_sel, m_ready,
        input  s_ready, m_valid, m_data, m_last
    );
endinterface

// File: rtl/stream_demux_1ton.sv
// Registered 1-to-NUM_OUT packet demultiplexer. The channel is captured on a
// packet's first beat; packets with an out-of-range select are dropped and counted.
module stream_demux_1ton #(
    parameter int DATA_W  = 8,
    parameter int NUM_OUT = 4,
    parameter int SEL_W   = 3,
    parameter int CNT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    stream_demux_1ton_if.slave   bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     drop_cnt
);
    localparam int CH_W = $clog2(NUM_OUT);

    typedef enum logic [1:0] {IDLE, ROUTE, DROP} state_t;

    state_t            state, state_nxt;
    logic              run;
    logic              ov;
    logic [CH_W-1:0]   och, cur_ch, load_ch;
    logic [DATA_W-1:0] data_q;
    logic              last_q;
    logic              sel_ok, drain, ready, accept, load, drop_inc;

    // run keeps s_ready low during reset and until the first edge after release
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        drop_inc  = 1'b0;
        load_ch   = cur_ch;
        sel_ok    = 32'(bus.s_sel) < NUM_OUT;
        drain     = ov && bus.m_ready[och];
        ready     = run && ((state == DROP) || !ov || bus.m_ready[och]);
        accept    = bus.s_valid && ready;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (sel_ok) begin
                        load    = 1'b1;
                        load_ch = bus.s_sel[CH_W-1:0];
                        if (!bus.s_last) state_nxt = ROUTE;
                    end else begin
                        drop_inc = 1'b1;
                        if (!bus.s_last) state_nxt = DROP;
                    end
                end
            end
            ROUTE: begin
                if (accept) begin
                    load = 1'b1;
                    if (bus.s_last) state_nxt = IDLE;
                end
            end
            DROP: begin
                if (accept && bus.s_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            run      <= 1'b0;
            ov       <= 1'b0;
            och      <= '0;
            cur_ch   <= '0;
            data_q   <= '0;
            last_q   <= 1'b0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            run   <= 1'b1;
            // a load in the same cycle as a drain keeps the register occupied
            if (load) begin
                ov     <= 1'b1;
                och    <= load_ch;
                data_q <= bus.s_data;
                last_q <= bus.s_last;
            end else if (drain) begin
                ov <= 1'b0;
            end
            if (load && state == IDLE) cur_ch <= load_ch;
            if (drop_inc && drop_cnt != '1) drop_cnt <= drop_cnt + 1'b1;
        end
    end

    assign bus.s_ready = ready;
    assign bus.m_valid = ov ? ({{(NUM_OUT-1){1'b0}}, 1'b1} << och) : '0;
    assign bus.m_data  = data_q;
    assign bus.m_last  = last_q;
    assign busy        = (state != IDLE) || ov;
endmodule

// File: tb/tb_stream_demux_1ton.sv
// Self-checking bench for stream_demux_1ton: table-driven packet stream with a
// scoreboard of expected routed beats, plus hand-written reset/backpressure/saturation cases.
module tb_stream_demux_1ton;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic [7:0] drop_cnt;

    stream_demux_1ton_if #(.DATA_W(8), .NUM_OUT(4), .SEL_W(3)) bus ();

    stream_demux_1ton #(.DATA_W(8), .NUM_OUT(4), .SEL_W(3), .CNT_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] ch;
        logic [7:0] data;
        logic       last;
    } exp_t;

    typedef struct {
        logic [2:0] sel;
        logic [7:0] data;
        logic       last;
        logic       route;
        logic [1:0] ch;
        logic       drop1st;
    } vec_t;

    exp_t sb[$];
    exp_t e;
    vec_t tbl[$];
    int   pop_log[$];
    int   cyc = 0;
    int   acc_cyc = 0;
    int   first_acc = 0;
    int   checks = 0;
    int   errors = 0;
    int   exp_drops = 0;
    logic seen_valid = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: a handshake completes at the next rising edge when valid meets ready
    always @(negedge clk) begin
        if (rst_n && bus.m_valid != '0) seen_valid = 1'b1;
        if (rst_n && (bus.m_valid & bus.m_ready) != '0) begin
            if (sb.size() == 0) begin
                chk("unexpected_beat", 32'(bus.m_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("m_valid", 32'(bus.m_valid), 32'(1) << e.ch);
                chk("m_data", 32'(bus.m_data), 32'(e.data));
                chk("m_last", 32'(bus.m_last), 32'(e.last));
                pop_log.push_back(cyc);
            end
        end
    end

    task automatic send_beat(input logic [2:0] sel, input logic [7:0] data, input logic last,
                             input logic route, input logic [1:0] ch, input logic drop1st);
        bus.s_valid = 1'b1;
        bus.s_sel   = sel;
        bus.s_data  = data;
        bus.s_last  = last;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (bus.s_ready) begin
                acc_cyc = cyc;
                if (route) sb.push_back('{ch, data, last});
                if (drop1st && exp_drops != 255) exp_drops++;
                @(posedge clk);
                #1;
                return;
            end
            @(posedge clk);
            #1;
        end
        chk("accept_timeout", 32'(bus.s_ready), 32'd1);
    endtask

    task automatic wait_drain();
        for (int w = 0; w < 200 && sb.size() != 0; w++) @(negedge clk);
        chk("drain", sb.size(), 32'd0);
    endtask

    initial begin
        rst_n       = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_sel   = '0;
        bus.s_data  = '0;
        bus.s_last  = 1'b0;
        bus.m_ready = '0;

        // Stream: 3-beat sel=2 with mid-packet sel change, back-to-back single
        // beats, dropped packet, single-beat drop, invalid sel ignored mid-packet
        tbl.push_back('{3'd2, 8'h11, 1'b0, 1'b1, 2'd2, 1'b0});
        tbl.push_back('{3'd1, 8'h22, 1'b0, 1'b1, 2'd2, 1'b0});
        tbl.push_back('{3'd1, 8'h33, 1'b1, 1'b1, 2'd2, 1'b0});
        tbl.push_back('{3'd0, 8'hA0, 1'b1, 1'b1, 2'd0, 1'b0});
        tbl.push_back('{3'd3, 8'hA3, 1'b1, 1'b1, 2'd3, 1'b0});
        tbl.push_back('{3'd1, 8'hA1, 1'b1, 1'b1, 2'd1, 1'b0});
        tbl.push_back('{3'd5, 8'hE0, 1'b0, 1'b0, 2'd0, 1'b1});
        tbl.push_back('{3'd5, 8'hE1, 1'b1, 1'b0, 2'd0, 1'b0});
        tbl.push_back('{3'd0, 8'h55, 1'b1, 1'b1, 2'd0, 1'b0});
        tbl.push_back('{3'd4, 8'h66, 1'b1, 1'b0, 2'd0, 1'b1});
        tbl.push_back('{3'd3, 8'h77, 1'b0, 1'b1, 2'd3, 1'b0});
        tbl.push_back('{3'd7, 8'h78, 1'b1, 1'b1, 2'd3, 1'b0});

        #1;
        chk("rst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("post_rst_s_ready", 32'(bus.s_ready), 32'd1);
        @(posedge clk);
        #1;

        // Reset mid-packet with the output register occupied
        send_beat(3'd6, 8'hD0, 1'b1, 1'b0, 2'd0, 1'b1);
        send_beat(3'd2, 8'h5A, 1'b0, 1'b1, 2'd2, 1'b0);
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("pre_rst_m_valid", 32'(bus.m_valid), 32'h4);
        chk("pre_rst_drop_cnt", 32'(drop_cnt), 32'd1);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_m_valid", 32'(bus.m_valid), 32'd0);
        chk("midrst_m_data", 32'(bus.m_data), 32'd0);
        chk("midrst_s_ready", 32'(bus.s_ready), 32'd0);
        chk("midrst_drop_cnt", 32'(drop_cnt), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        sb.delete();
        exp_drops = 0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rel_s_ready", 32'(bus.s_ready), 32'd1);
        chk("rel_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;

        // Table-driven stream, all consumers ready, s_valid held continuously
        bus.m_ready = 4'b1111;
        pop_log.delete();
        foreach (tbl[i]) begin
            send_beat(tbl[i].sel, tbl[i].data, tbl[i].last, tbl[i].route, tbl[i].ch, tbl[i].drop1st);
            if (i == 0) first_acc = acc_cyc;
        end
        bus.s_valid = 1'b0;
        wait_drain();
        @(negedge clk);
        chk("busy_after_drain", 32'(busy), 32'd0);
        chk("drop_cnt_tbl", 32'(drop_cnt), 32'(exp_drops));
        chk("pop_count", pop_log.size(), 32'd9);
        if (pop_log.size() == 9) begin
            chk("latency", pop_log[0] - first_acc, 32'd1);
            for (int k = 1; k < 6; k++) chk("no_bubble", pop_log[k] - pop_log[k-1], 32'd1);
        end

        // Backpressure on channel 1 only; other ready bits must not matter
        @(posedge clk);
        #1;
        bus.m_ready = 4'b1101;
        send_beat(3'd1, 8'h41, 1'b0, 1'b1, 2'd1, 1'b0);
        bus.s_data = 8'h42;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_s_ready", 32'(bus.s_ready), 32'd0);
            chk("bp_m_data", 32'(bus.m_data), 32'h41);
            chk("bp_m_valid", 32'(bus.m_valid), 32'h2);
            @(posedge clk);
            #1;
        end
        bus.m_ready = 4'b1111;
        send_beat(3'd1, 8'h42, 1'b0, 1'b1, 2'd1, 1'b0);
        send_beat(3'd6, 8'h43, 1'b1, 1'b1, 2'd1, 1'b0);
        bus.s_valid = 1'b0;
        wait_drain();

        // Counter saturation with invalid single-beat packets
        @(posedge clk);
        #1;
        seen_valid = 1'b0;
        for (int k = 0; k < 300; k++) send_beat(3'd7, 8'(k), 1'b1, 1'b0, 2'd0, 1'b1);
        bus.s_valid = 1'b0;
        @(negedge clk);
        chk("sat_drop_cnt", 32'(drop_cnt), 32'(exp_drops));
        chk("sat_drop_cnt_ff", 32'(drop_cnt), 32'hFF);
        chk("sat_no_valid", 32'(seen_valid), 32'd0);
        chk("sb_empty", sb.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
